// File: rtl/hs_cdc_pacer_pkg.sv
// Shared types and limits for the pulse-CDC source-side pacer.
package hs_cdc_pacer_pkg;

    typedef enum logic [1:0] {
        PACER_IDLE = 2'd0,
        PACER_EMIT = 2'd1,
        PACER_GAP  = 2'd2
    } pacer_state_e;

    typedef enum logic [1:0] {
        LEVEL_LOW  = 2'd0,
        LEVEL_HIGH = 2'd1,
        LEVEL_ANY  = 2'd2
    } level_e;

    localparam int unsigned PACER_GAP_W   = 8;
    localparam int unsigned MIN_GAP_LO    = 1;
    localparam int unsigned MIN_GAP_HI    = 255;
    localparam int unsigned CNT_W_LO      = 1;
    localparam int unsigned CNT_W_HI      = 16;

    function automatic logic level_drive(input level_e lvl, input logic active);
        return (lvl == LEVEL_LOW) ? ~active : active;
    endfunction

endpackage

// File: rtl/hs_unit_sat_updn_cnt.sv
// Up/down counter that saturates at all-ones and never wraps below zero.
module hs_unit_sat_updn_cnt #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             inc,
    input  logic             dec,
    input  logic             sclr,
    output logic [WIDTH-1:0] dout,
    output logic             sat_hit
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = cnt_q;
        sat_hit = 1'b0;
        if (sclr) begin
            cnt_d = '0;
        end else if (inc && !dec) begin
            if (cnt_q == CNT_MAX) begin
                sat_hit = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (dec && !inc && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign dout = cnt_q;

endmodule

// File: rtl/hs_cdc_pulse_pacer.sv
// Paces bursty source events into gap-separated pulses for the pulse CDC syncer
// and handles the syncer's overload feedback.
module hs_cdc_pulse_pacer
    import hs_cdc_pacer_pkg::*;
#(
    parameter int unsigned CNT_W        = 4,
    parameter int unsigned MIN_GAP      = 8,
    parameter level_e      ACTIVE_LEVEL = LEVEL_HIGH
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             event_in,
    input  logic             pend_clr,
    input  logic             err_clr,
    output logic             pulse_out,
    output logic [CNT_W-1:0] pending,
    output logic             busy,
    output logic             evt_overflow,
    input  logic             ovld_in,
    output logic             ovld_sclr,
    output logic             link_err
);

    if ((MIN_GAP < MIN_GAP_LO) || (MIN_GAP > MIN_GAP_HI)) begin : g_bad_gap
        $error("hs_cdc_pulse_pacer: MIN_GAP out of range");
    end
    if ((CNT_W < CNT_W_LO) || (CNT_W > CNT_W_HI)) begin : g_bad_cnt_w
        $error("hs_cdc_pulse_pacer: CNT_W out of range");
    end
    if ((ACTIVE_LEVEL != LEVEL_HIGH) && (ACTIVE_LEVEL != LEVEL_LOW)) begin : g_bad_level
        $error("hs_cdc_pulse_pacer: ACTIVE_LEVEL must be LEVEL_HIGH or LEVEL_LOW");
    end

    localparam logic [PACER_GAP_W-1:0] GAP_RELOAD = PACER_GAP_W'(MIN_GAP - 1);

    pacer_state_e            state_q, state_d;
    logic [PACER_GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic                    dec;
    logic                    sat_hit;
    logic                    evt_overflow_q;
    logic                    ovld_sclr_q;
    logic                    link_err_q;
    logic                    link_set;

    hs_unit_sat_updn_cnt #(
        .WIDTH (CNT_W)
    ) u_pend_cnt (
        .clk     (clk),
        .areset  (areset),
        .inc     (event_in),
        .dec     (dec),
        .sclr    (pend_clr),
        .dout    (pending),
        .sat_hit (sat_hit)
    );

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        dec       = 1'b0;
        unique case (state_q)
            PACER_IDLE: begin
                if (pending != '0) state_d = PACER_EMIT;
            end
            PACER_EMIT: begin
                dec       = 1'b1;
                state_d   = PACER_GAP;
                gap_cnt_d = GAP_RELOAD;
            end
            PACER_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = (pending != '0) ? PACER_EMIT : PACER_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = PACER_IDLE;
        endcase
    end

    // A held ovld_in is masked for the cycle the clear is on the wire.
    assign link_set = ovld_in & ~ovld_sclr_q;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q        <= PACER_IDLE;
            gap_cnt_q      <= '0;
            evt_overflow_q <= 1'b0;
            ovld_sclr_q    <= 1'b0;
            link_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            gap_cnt_q      <= gap_cnt_d;
            ovld_sclr_q    <= link_set;
            evt_overflow_q <= sat_hit  ? 1'b1 : (err_clr ? 1'b0 : evt_overflow_q);
            link_err_q     <= link_set ? 1'b1 : (err_clr ? 1'b0 : link_err_q);
        end
    end

    assign pulse_out    = level_drive(ACTIVE_LEVEL, state_q == PACER_EMIT);
    assign busy         = (state_q != PACER_IDLE) || (pending != '0);
    assign evt_overflow = evt_overflow_q;
    assign ovld_sclr    = ovld_sclr_q;
    assign link_err     = link_err_q;

endmodule

// File: tb/tb_hs_cdc_pulse_pacer.sv
// Directed bench for hs_cdc_pulse_pacer: default, narrow-counter and active-low instances.
module tb_hs_cdc_pulse_pacer;
    import hs_cdc_pacer_pkg::*;

    logic clk = 1'b0;
    logic areset, event_in, pend_clr, err_clr, ovld_in;

    logic       pulse_a, busy_a, ovf_a, sclr_a, lerr_a;
    logic [3:0] pend_a;
    logic       pulse_s, busy_s, ovf_s, sclr_s, lerr_s;
    logic [1:0] pend_s;
    logic       pulse_l, busy_l, ovf_l, sclr_l, lerr_l;
    logic [3:0] pend_l;

    int checks = 0;
    int errors = 0;
    int pulses;
    logic exp_p;

    always #5 clk = ~clk;

    hs_cdc_pulse_pacer dut_a (
        .clk(clk), .areset(areset), .event_in(event_in), .pend_clr(pend_clr),
        .err_clr(err_clr), .pulse_out(pulse_a), .pending(pend_a), .busy(busy_a),
        .evt_overflow(ovf_a), .ovld_in(ovld_in), .ovld_sclr(sclr_a), .link_err(lerr_a)
    );

    hs_cdc_pulse_pacer #(.CNT_W(2)) dut_s (
        .clk(clk), .areset(areset), .event_in(event_in), .pend_clr(pend_clr),
        .err_clr(err_clr), .pulse_out(pulse_s), .pending(pend_s), .busy(busy_s),
        .evt_overflow(ovf_s), .ovld_in(ovld_in), .ovld_sclr(sclr_s), .link_err(lerr_s)
    );

    hs_cdc_pulse_pacer #(.ACTIVE_LEVEL(LEVEL_LOW)) dut_l (
        .clk(clk), .areset(areset), .event_in(event_in), .pend_clr(pend_clr),
        .err_clr(err_clr), .pulse_out(pulse_l), .pending(pend_l), .busy(busy_l),
        .evt_overflow(ovf_l), .ovld_in(ovld_in), .ovld_sclr(sclr_l), .link_err(lerr_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        areset   = 1'b1;
        event_in = 1'b0;
        pend_clr = 1'b0;
        err_clr  = 1'b0;
        ovld_in  = 1'b0;
        tick();
        tick();
        areset   = 1'b0;
    endtask

    initial begin
        // Reset state
        areset = 1'b1; event_in = 1'b0; pend_clr = 1'b0; err_clr = 1'b0; ovld_in = 1'b0;
        tick();
        chk("rst_pulse_hi", 32'(pulse_a), 32'd0);
        chk("rst_pulse_lo", 32'(pulse_l), 32'd1);
        chk("rst_pending",  32'(pend_a),  32'd0);
        chk("rst_busy",     32'(busy_a),  32'd0);
        chk("rst_ovf",      32'(ovf_a),   32'd0);
        chk("rst_sclr",     32'(sclr_a),  32'd0);
        chk("rst_lerr",     32'(lerr_a),  32'd0);

        // 1: single event latency
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            event_in = (c == 0);
            chk("s1_pulse", 32'(pulse_a), 32'(c == 2));
            if (c == 0)  chk("s1_pend_c0", 32'(pend_a), 32'd0);
            if (c == 1)  chk("s1_pend_c1", 32'(pend_a), 32'd1);
            if (c == 3)  chk("s1_pend_c3", 32'(pend_a), 32'd0);
            if (c == 10) chk("s1_busy_c10", 32'(busy_a), 32'd1);
            if (c == 11) chk("s1_busy_c11", 32'(busy_a), 32'd0);
            tick();
        end

        // 2 + 6: five-event burst, high and low polarity
        do_reset();
        for (int c = 0; c <= 47; c++) begin
            event_in = (c < 5);
            exp_p = (c == 2) || (c == 11) || (c == 20) || (c == 29) || (c == 38);
            chk("s2_pulse", 32'(pulse_a), 32'(exp_p));
            chk("s6_pulse_low", 32'(pulse_l), 32'(!exp_p));
            if (c == 5)  chk("s2_pend_peak", 32'(pend_a), 32'd4);
            if (c == 46) chk("s2_busy_c46", 32'(busy_a), 32'd1);
            if (c == 47) chk("s2_busy_c47", 32'(busy_a), 32'd0);
            tick();
        end
        chk("s2_no_ovf", 32'(ovf_a), 32'd0);

        // 3: saturation with CNT_W=2
        do_reset();
        pulses = 0;
        for (int c = 0; c <= 45; c++) begin
            event_in = (c < 6);
            pulses += int'(pulse_s);
            if (c == 4) chk("s3_ovf_early", 32'(ovf_s), 32'd0);
            if (c == 5) chk("s3_pend_sat", 32'(pend_s), 32'd3);
            if (c == 6) chk("s3_ovf_set", 32'(ovf_s), 32'd1);
            tick();
        end
        chk("s3_pulse_count", 32'(pulses), 32'd4);
        chk("s3_ovf_sticky", 32'(ovf_s), 32'd1);
        chk("s3_wide_no_ovf", 32'(ovf_a), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("s3_ovf_clr", 32'(ovf_s), 32'd0);

        // 4: pend_clr mid-burst
        do_reset();
        for (int c = 0; c <= 30; c++) begin
            event_in = (c < 5);
            pend_clr = (c == 5);
            chk("s4_pulse", 32'(pulse_a), 32'(c == 2));
            if (c == 6)  chk("s4_pend_c6", 32'(pend_a), 32'd0);
            if (c == 10) chk("s4_busy_c10", 32'(busy_a), 32'd1);
            if (c == 11) chk("s4_busy_c11", 32'(busy_a), 32'd0);
            tick();
        end
        pend_clr = 1'b0;

        // 5: overload feedback, retrigger and err_clr-vs-set
        do_reset();
        for (int c = 0; c <= 16; c++) begin
            event_in = (c == 0);
            ovld_in  = (c == 0) || (c == 1) || ((c >= 10) && (c <= 13));
            err_clr  = (c == 6) || (c == 12);
            chk("s5_pulse", 32'(pulse_a), 32'(c == 2));
            chk("s5_sclr", 32'(sclr_a), 32'((c == 1) || (c == 11) || (c == 13)));
            chk("s5_lerr", 32'(lerr_a), 32'(((c >= 1) && (c <= 6)) || (c >= 11)));
            tick();
        end
        ovld_in = 1'b0;
        err_clr = 1'b0;

        // 7: areset during GAP with backlog and sticky flags set
        do_reset();
        for (int c = 0; c <= 4; c++) begin
            event_in = 1'b1;
            ovld_in  = (c == 3);
            tick();
        end
        event_in = 1'b0;
        ovld_in  = 1'b0;
        chk("s7_pre_pend", 32'(pend_a), 32'd4);
        chk("s7_pre_lerr", 32'(lerr_a), 32'd1);
        chk("s7_pre_ovf_s", 32'(ovf_s), 32'd1);
        areset = 1'b1;
        #1;
        chk("s7_pulse_hi", 32'(pulse_a), 32'd0);
        chk("s7_pulse_lo", 32'(pulse_l), 32'd1);
        chk("s7_pend", 32'(pend_a), 32'd0);
        chk("s7_busy", 32'(busy_a), 32'd0);
        chk("s7_lerr", 32'(lerr_a), 32'd0);
        chk("s7_sclr", 32'(sclr_a), 32'd0);
        chk("s7_ovf_s", 32'(ovf_s), 32'd0);

        // areset while pulse_out is active drops it without a clock
        do_reset();
        event_in = 1'b1;
        tick();
        event_in = 1'b0;
        tick();
        chk("s7_emit_pulse", 32'(pulse_a), 32'd1);
        areset = 1'b1;
        #1;
        chk("s7_emit_drop", 32'(pulse_a), 32'd0);
        areset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
